// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the UART-driven status-register controller.
package mem_ctrl_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned MEM_W  = 6;
    localparam int unsigned CNT_W  = 16;

    localparam logic [BYTE_W-1:0] CMD_WRITE = 8'hA5;
    localparam logic [BYTE_W-1:0] CMD_READ  = 8'h5A;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_PAY = 2'd1,
        TX_RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/mem_ctrl_if.sv
// Byte stream, response stream and status-register write bus around mem_ctrl.
interface mem_ctrl_if;
    import mem_ctrl_pkg::*;

    logic [BYTE_W-1:0] in_rx_data;
    logic              in_rx_valid;
    logic [MEM_W-1:0]  in_mem;
    logic [BYTE_W-1:0] out_uart;
    logic              out_uart_en;
    logic              out_key;
    logic              out_key_en;
    logic [BYTE_W-1:0] out_tx_data;
    logic              out_tx_valid;
    logic              in_tx_ready;

    // Host/environment side: supplies bytes, register value and tx ready.
    modport master (
        output in_rx_data, in_rx_valid, in_mem, in_tx_ready,
        input  out_uart, out_uart_en, out_key, out_key_en, out_tx_data, out_tx_valid
    );

    // Controller side.
    modport slave (
        input  in_rx_data, in_rx_valid, in_mem, in_tx_ready,
        output out_uart, out_uart_en, out_key, out_key_en, out_tx_data, out_tx_valid
    );

endinterface

// File: rtl/mem_ctrl_key_debounce.sv
// Two-flop synchronizer followed by a stable-time debouncer for a push button.
module key_debounce
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic in_clk,
    input  logic in_rst_n,
    input  logic in_key_raw,
    output logic out_level,
    output logic out_change
);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous level into the clock domain.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= in_key_raw;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after it has held for DEB_CYCLES clocks; any bounce restarts.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            cnt        <= '0;
            out_level  <= 1'b0;
            out_change <= 1'b0;
        end else begin
            out_change <= 1'b0;
            if (sync2 != out_level) begin
                if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
                    out_level  <= sync2;
                    out_change <= 1'b1;
                    cnt        <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// UART command decoder writing a status register, plus debounced key writes.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned DEB_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic           in_clk,
    input  logic           in_rst_n,
    input  logic           in_key_raw,
    mem_ctrl_if.slave      bus,
    output logic           out_err
);

    state_t            state;
    logic [CNT_W-1:0]  to_cnt;
    logic [BYTE_W-1:0] uart_q;
    logic              uart_en_q;
    logic              key_q;
    logic              key_en_q;
    logic [BYTE_W-1:0] tx_data_q;
    logic              tx_valid_q;
    logic              key_pend;
    logic              deb_level;
    logic              deb_change;
    logic              key_req;
    logic              uart_wr;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .in_clk     (in_clk),
        .in_rst_n   (in_rst_n),
        .in_key_raw (in_key_raw),
        .out_level  (deb_level),
        .out_change (deb_change)
    );

    assign key_req = deb_change | key_pend;
    assign uart_wr = (state == WAIT_PAY) && bus.in_rx_valid;

    assign bus.out_uart     = uart_q;
    assign bus.out_uart_en  = uart_en_q;
    assign bus.out_key      = key_q;
    assign bus.out_key_en   = key_en_q;
    assign bus.out_tx_data  = tx_data_q;
    assign bus.out_tx_valid = tx_valid_q;

    // Command FSM and key-write arbitration; a UART write always takes the slot first.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state      <= IDLE;
            to_cnt     <= '0;
            uart_q     <= '0;
            uart_en_q  <= 1'b0;
            key_q      <= 1'b0;
            key_en_q   <= 1'b0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            key_pend   <= 1'b0;
            out_err    <= 1'b0;
        end else begin
            uart_en_q <= 1'b0;
            key_en_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_rx_valid) begin
                        if (bus.in_rx_data == CMD_WRITE) begin
                            state   <= WAIT_PAY;
                            to_cnt  <= '0;
                            out_err <= 1'b0;
                        end else if (bus.in_rx_data == CMD_READ) begin
                            tx_data_q  <= {2'b00, bus.in_mem};
                            tx_valid_q <= 1'b1;
                            state      <= TX_RESP;
                            out_err    <= 1'b0;
                        end else begin
                            out_err <= 1'b1;
                        end
                    end
                end
                WAIT_PAY: begin
                    if (bus.in_rx_valid) begin
                        uart_q    <= bus.in_rx_data;
                        uart_en_q <= 1'b1;
                        state     <= IDLE;
                    end else if (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        out_err <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + CNT_W'(1);
                    end
                end
                TX_RESP: begin
                    if (bus.in_rx_valid) begin
                        out_err <= 1'b1;
                    end
                    if (bus.in_tx_ready) begin
                        tx_valid_q <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (key_req) begin
                if (uart_wr) begin
                    key_pend <= 1'b1;
                end else begin
                    key_en_q <= 1'b1;
                    key_q    <= deb_level;
                    key_pend <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 16, key debounce stable-time in clocks (legal range 2..65535).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000, maximum idle clocks allowed between header and payload byte (legal range 1..65535).
REQ-003 SHALL have port in_clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port in_rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_rx_data  input  8  received UART byte.
REQ-006 SHALL have port in_rx_valid  input  1  one-cycle strobe qualifying in_rx_data.
REQ-007 SHALL have port in_key_raw  input  1  raw, asynchronous push-button level.
REQ-008 SHALL have port in_mem  input  6  current status-register value, for readback.
REQ-009 SHALL have port out_uart  output  8  status-register write data, UART path.
REQ-010 SHALL have port out_uart_en  output  1  one-cycle write strobe, UART path.
REQ-011 SHALL have port out_key  output  1  status-register bit-5 write data, key path.
REQ-012 SHALL have port out_key_en  output  1  one-cycle write strobe, key path.
REQ-013 SHALL have port out_tx_data  output  8  response byte to UART transmitter.
REQ-014 SHALL have port out_tx_valid  output  1  response valid; held until accepted.
REQ-015 SHALL have port in_tx_ready  input  1  transmitter accepts when valid and ready are both high.
REQ-016 SHALL have port out_err  output  1  sticky protocol error flag.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT_PAY, TX_RESP.
REQ-018 In IDLE, a byte 0xA5 (CMD_WRITE) SHALL move the FSM to WAIT_PAY and clear the timeout counter.
REQ-019 In IDLE, a byte 0x5A (CMD_READ) SHALL latch {2'b00, in_mem} into out_tx_data, assert out_tx_valid on the next cycle and move to TX_RESP.
REQ-020 In IDLE, any other byte SHALL set out_err; the FSM stays in IDLE.
REQ-021 In WAIT_PAY, a byte SHALL drive out_uart = byte with out_uart_en high for exactly one cycle, on the cycle after the byte strobe, and the FSM SHALL return to IDLE.
REQ-022 In WAIT_PAY, when TIMEOUT_CYCLES clocks elapse without a byte, the FSM SHALL set out_err and return to IDLE with no write.
REQ-023 In TX_RESP, out_tx_data and out_tx_valid SHALL remain stable until the handshake; on the handshake cycle out_tx_valid SHALL drop on the next edge and the FSM SHALL return to IDLE.
REQ-024 A byte received in TX_RESP SHALL be discarded and SHALL set out_err.
REQ-025 out_err SHALL clear only when a valid CMD_WRITE or CMD_READ byte is accepted in IDLE; if set and clear coincide, clear wins.
REQ-026 in_key_raw SHALL pass through a 2-flop synchronizer before debounce.
REQ-027 The debounced level SHALL change only after the synchronized level has differed from it for DEB_CYCLES consecutive clocks; any bounce SHALL restart the count.
REQ-028 Each debounced level change SHALL raise a key write request: out_key = new level, out_key_en pulsed for one cycle.
REQ-029 If a key write request coincides with an out_uart_en cycle, the UART write SHALL issue first; the key write SHALL be held pending and issued on the following cycle.
REQ-030 out_uart_en and out_key_en SHALL never be high in the same cycle.
REQ-031 A pending key write SHALL never be lost or duplicated.

Reset
REQ-032 Asserting in_rst_n low SHALL immediately force state IDLE; all outputs 0; synchronizer flops, debounced level, counters and pending flag 0.
REQ-033 Reset mid-transaction (WAIT_PAY or TX_RESP) SHALL abandon it with no write strobe and no tx valid after release.

Structure
REQ-034 Package mem_ctrl_pkg SHALL hold the state enum type and constants CMD_WRITE = 8'hA5 and CMD_READ = 8'h5A.
REQ-035 Synchronizer and debounce logic SHALL be a sub-module key_debounce that outputs the debounced level and a one-cycle change pulse.

Verification
REQ-036 Bytes 0xA5, 0x2B -> exactly one out_uart_en pulse with out_uart = 0x2B, one cycle after the 0x2B strobe; out_err = 0.
REQ-037 in_mem = 6'h15, byte 0x5A, in_tx_ready held low for 5 cycles then high -> out_tx_data = 0x15 stable with valid high throughout; valid drops after the handshake.
REQ-038 Byte 0x33 in IDLE -> out_err = 1; then 0x5A -> out_err = 0.
REQ-039 0xA5 followed by TIMEOUT_CYCLES idle clocks -> out_err = 1; no out_uart_en; a later byte 0x07 is treated as a command (error).
REQ-040 DEB_CYCLES = 16; key bounces (toggle every 3 cycles), then stays high 16+ cycles -> exactly one out_key_en with out_key = 1.
REQ-041 Force a key change pulse in the same cycle as a UART payload write -> out_uart_en in cycle N, out_key_en in cycle N+1, never both high.
